// File: rtl/ex2_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex2_div_unit
// Purpose  : Iterative radix-2 restoring divider for the EX2 stage
//            (div.w, mod.w, div.wu, mod.wu), one quotient bit per cycle.
// Options  : DIV_EARLY_EXIT_EN - finish in one cycle when the divisor is
//            zero or the dividend magnitude is below the divisor magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module ex2_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             res_ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Operation context captured at accept time
  logic             mod_sel;   // op[0]: return remainder instead of quotient
  logic             sa, sb;    // operand sign flags (signed ops only)
  logic             dz;        // divisor was zero
  logic [WIDTH-1:0] dvd;       // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dsr;       // divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] quot;      // quotient being assembled
  logic [CW-1:0]    cnt;       // iteration counter 0..WIDTH-1

  logic             accept, in_sa, in_sb, last, ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff, rem_nx, quot_nx, q_fix, r_fix, fin;
  logic             early;
  logic [WIDTH-1:0] early_res;

  // A new divide is taken from IDLE, or from DONE when the held result is
  // consumed in the same cycle; a flush always wins over start.
  assign accept = start & ~flush & ((state == IDLE) | ((state == DONE) & res_ack));

  assign in_sa = src_a[WIDTH-1] & ~op[1];
  assign in_sb = src_b[WIDTH-1] & ~op[1];
  assign a_mag = in_sa ? -src_a : src_a;
  assign b_mag = in_sb ? -src_b : src_b;

  // One restoring step. The partial remainder keeps its top bit so that
  // unsigned divisors above 2^(WIDTH-1) are handled correctly.
  assign part    = {rem, dvd[WIDTH-1]};
  assign ge      = (part >= {1'b0, dsr});
  assign diff    = part[WIDTH-1:0] - dsr;
  assign rem_nx  = ge ? diff : part[WIDTH-1:0];
  assign quot_nx = {quot[WIDTH-2:0], ge};
  assign last    = (cnt == CW'(WIDTH - 1));

  // Sign correction; divide-by-zero pins the quotient to all ones while the
  // remainder naturally comes back as the original dividend.
  assign q_fix = dz ? '1 : ((sa ^ sb) ? -quot_nx : quot_nx);
  assign r_fix = sa ? -rem_nx : rem_nx;
  assign fin   = mod_sel ? r_fix : q_fix;

`ifdef DIV_EARLY_EXIT_EN
  assign early     = (b_mag == '0) | (a_mag < b_mag);
  assign early_res = op[0] ? src_a : ((b_mag == '0) ? '1 : '0);
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; flush returns to IDLE from anywhere
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = early ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (res_ack) state_nx = accept ? (early ? DONE : CALC) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mod_sel <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dz      <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      quot    <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      mod_sel <= op[0];
      sa      <= in_sa;
      sb      <= in_sb;
      dz      <= (src_b == '0);
      dvd     <= a_mag;
      dsr     <= b_mag;
      rem     <= '0;
      quot    <= '0;
      cnt     <= '0;
      if (early) result <= early_res;
    end else if ((state == CALC) && !flush) begin
      dvd  <= {dvd[WIDTH-2:0], 1'b0};
      rem  <= rem_nx;
      quot <= quot_nx;
      cnt  <= cnt + 1'b1;
      if (last) result <= fin;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex2_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex2_div_unit
// Purpose  : Self-checking bench for ex2_div_unit with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex2_div_unit;

  logic        clk = 1'b0;
  logic        areset, flush, start, res_ack;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  ex2_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .areset(areset), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .res_ack(res_ack),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Hard stop in case the bench itself wedges
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from plain language arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return o[0] ? a : 32'hFFFFFFFF;
    if (!o[1]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return o[0] ? 32'h0 : 32'h80000000;
      return o[0] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return o[0] ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
    logic [31:0] am, bm;
    am = (!o[1] && a[31]) ? -a : a;
    bm = (!o[1] && b[31]) ? -b : b;
    if (bm == 32'h0 || am < bm) return 1;
`endif
    return 33;
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
  endtask

  // Called at the negedge of cycle T+1; returns k such that done rose in T+k
  task automatic wait_done(output int k, output int drops, input bit noise);
    k = 1; drops = 0;
    if (!busy) drops++;
    while (!done && k < 60) begin
      if (noise && k == 5) begin
        start = 1'b1; op = 2'b10; src_a = 32'h12345678; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (!busy) drops++;
    end
    start = 1'b0;
  endtask

  task automatic compare_result(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: result %h with empty scoreboard", tag, result);
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, result, last_exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit noise);
    int k, drops, lat;
    lat = exp_lat(o, a, b);
    @(negedge clk);
    drive_start(o, a, b);
    @(negedge clk);
    start = 1'b0;
    wait_done(k, drops, noise);
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_busy_drops"}, 32'(drops), 32'd0);
    compare_result({tag, "_res"});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_hold_res"}, result, last_exp);
      check({tag, "_hold_done"}, 32'(done), 32'd1);
    end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check({tag, "_ack_done"}, 32'(done), 32'd0);
    check({tag, "_ack_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, drops;
    areset = 1'b1; flush = 1'b0; start = 1'b0; res_ack = 1'b0;
    op = 2'b00; src_a = 32'h0; src_b = 32'h0;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    areset = 1'b0;

    // Basic unsigned and signed operations, overflow, divide-by-zero
    run_op("udiv",   2'b10, 32'd100, 32'd7, 0, 1'b0);
    run_op("umod",   2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op("sdiv",   2'b00, -32'sd7, 32'd2, 0, 1'b0);
    run_op("smod",   2'b01, -32'sd7, 32'd2, 0, 1'b0);
    run_op("ovf_d",  2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    run_op("ovf_m",  2'b01, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    run_op("dz_d",   2'b00, 32'd5, 32'd0, 0, 1'b0);
    run_op("dz_m",   2'b01, 32'd5, 32'd0, 0, 1'b0);
    run_op("dz_nd",  2'b00, -32'sd5, 32'd0, 0, 1'b0);
    run_op("dz_nm",  2'b01, -32'sd5, 32'd0, 0, 1'b0);
    run_op("dz_ud",  2'b10, 32'hFFFFFFF0, 32'd0, 0, 1'b0);
    run_op("small",  2'b00, 32'd3, 32'd10, 0, 1'b0);
    run_op("small_m",2'b01, -32'sd3, 32'd10, 0, 1'b0);
    run_op("bigdiv", 2'b11, 32'hFFFFFFFF, 32'h80000001, 0, 1'b0);
    // Result held while res_ack stays low; start pulses during CALC ignored
    run_op("hold",   2'b00, 32'd1000, -32'sd3, 10, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op($sformatf("rnd%0d", i), ro, ra, rb, 0, 1'b0);
    end

    // Back-to-back: ack and start in the DONE cycle
    @(negedge clk);
    drive_start(2'b10, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    wait_done(k, drops, 1'b0);
    check("b2b1_lat", 32'(k), 32'd33);
    compare_result("b2b1_res");
    res_ack = 1'b1;
    drive_start(2'b11, 32'd100, 32'd7);
    @(negedge clk);
    res_ack = 1'b0; start = 1'b0;
    wait_done(k, drops, 1'b0);
    check("b2b2_lat", 32'(k), 32'd33);
    check("b2b2_busy_drops", 32'(drops), 32'd0);
    compare_result("b2b2_res");
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("b2b2_ack_busy", 32'(busy), 32'd0);

    // Flush at iteration 10 with a simultaneous start that must be dropped
    @(negedge clk);
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1; start = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_done", 32'(done), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", result, last_exp);
    repeat (3) @(negedge clk);
    check("flush_start_dropped", 32'(busy), 32'd0);

    // Asynchronous reset at iteration 20
    @(negedge clk);
    op = 2'b00; src_a = 32'd999; src_b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 areset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'h0);
    @(negedge clk);
    areset = 1'b0;
    run_op("post_rst", 2'b00, 32'd999, 32'd4, 0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
